alt_sample_stats: RTL and testbench

Downstream consumer of the altimeter controller's I2C read burst. It assembles the 5-byte MPL3115A2 data block (OUT_P_MSB..OUT_T_LSB) from the I2C master's read-byte stream into 20-bit pressure and temperature samples. It maintains delta, min and max statistics and publishes a one-cycle sample strobe to the display/logging stages.

---
 rtl/alt_sample_stats.sv | 187 ++++++++++++++++++
 tb/tb_alt_sample_stats.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_sample_stats.sv
// Assembles MPL3115A2 OUT_P_MSB..OUT_T_LSB read bytes into 20-bit samples and tracks statistics.
// Optional `ALT_STATS_CLEAR_EN adds a synchronous statistics clear input.
module alt_sample_stats #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        frame_start,
    input  logic        frame_abort,
`ifdef ALT_STATS_CLEAR_EN
    input  logic        stats_clear,
`endif
    output logic [19:0] pressure,
    output logic [19:0] temp,
    output logic [19:0] delta_pressure,
    output logic [19:0] delta_temp,
    output logic [19:0] min_pressure,
    output logic [19:0] max_pressure,
    output logic [19:0] min_temp,
    output logic [19:0] max_temp,
    output logic        sample_valid,
    output logic        stats_valid,
    output logic [15:0] sample_count,
    output logic        frame_drop
);

    localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_PMSB, S_PCSB, S_PLSB, S_TMSB, S_TLSB} state_e;

    state_e          state_q, state_d, take_slot;
    logic [GapW-1:0] gap_q, gap_d;
    logic            drop_d, commit_d, commit_q, take;
    logic [7:0]      p_msb_q, p_csb_q, t_msb_q;
    logic [3:0]      p_lsb_q;
    logic [19:0]     pend_p_q, pend_t_q;
    logic            first;
    logic [20:0]     dp_raw, dt_raw;

    // Assembler next state: abort beats resync beats normal advance beats gap timeout.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        drop_d    = 1'b0;
        commit_d  = 1'b0;
        take      = 1'b0;
        take_slot = state_q;
        if (frame_abort) begin
            state_d = S_PMSB;
            gap_d   = '0;
            drop_d  = (state_q != S_PMSB);
        end else if (byte_valid && frame_start) begin
            take      = 1'b1;
            take_slot = S_PMSB;
            state_d   = S_PCSB;
            gap_d     = '0;
            drop_d    = (state_q != S_PMSB);
        end else if (byte_valid && state_q != S_PMSB) begin
            take  = 1'b1;
            gap_d = '0;
            case (state_q)
                S_PCSB:  state_d = S_PLSB;
                S_PLSB:  state_d = S_TMSB;
                S_TMSB:  state_d = S_TLSB;
                S_TLSB: begin
                    state_d  = S_PMSB;
                    commit_d = 1'b1;
                end
                default: state_d = S_PMSB;
            endcase
        end else if (state_q != S_PMSB) begin
            if (gap_q == GapW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_PMSB;
                gap_d   = '0;
                drop_d  = 1'b1;
            end else begin
                gap_d = gap_q + GapW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PMSB;
            gap_q      <= '0;
            frame_drop <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            frame_drop <= drop_d;
            commit_q   <= commit_d;
        end
    end

    // The full sample is latched on the last byte so the next frame may reuse staging at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_msb_q  <= '0;
            p_csb_q  <= '0;
            p_lsb_q  <= '0;
            t_msb_q  <= '0;
            pend_p_q <= '0;
            pend_t_q <= '0;
        end else if (take) begin
            case (take_slot)
                S_PMSB: p_msb_q <= byte_data;
                S_PCSB: p_csb_q <= byte_data;
                S_PLSB: p_lsb_q <= byte_data[7:4];
                S_TMSB: t_msb_q <= byte_data;
                S_TLSB: begin
                    pend_p_q <= {p_msb_q, p_csb_q, p_lsb_q};
                    pend_t_q <= {{8{t_msb_q[7]}}, t_msb_q, byte_data[7:4]};
                end
                default: ;
            endcase
        end
    end

    function automatic logic [19:0] sat20(input logic [20:0] d);
        if (d[20] != d[19]) return d[20] ? 20'h80000 : 20'h7FFFF;
        return d[19:0];
    endfunction

`ifdef ALT_STATS_CLEAR_EN
    assign first = !stats_valid || stats_clear;
`else
    assign first = !stats_valid;
`endif
    assign dp_raw = {1'b0, pend_p_q} - {1'b0, pressure};
    assign dt_raw = {pend_t_q[19], pend_t_q} - {temp[19], temp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressure       <= '0;
            temp           <= '0;
            delta_pressure <= '0;
            delta_temp     <= '0;
            min_pressure   <= '0;
            max_pressure   <= '0;
            min_temp       <= '0;
            max_temp       <= '0;
            sample_valid   <= 1'b0;
            stats_valid    <= 1'b0;
            sample_count   <= '0;
        end else if (commit_q) begin
            pressure     <= pend_p_q;
            temp         <= pend_t_q;
            sample_valid <= 1'b1;
            stats_valid  <= 1'b1;
            if (first) begin
                delta_pressure <= '0;
                delta_temp     <= '0;
                min_pressure   <= pend_p_q;
                max_pressure   <= pend_p_q;
                min_temp       <= pend_t_q;
                max_temp       <= pend_t_q;
                sample_count   <= 16'd1;
            end else begin
                delta_pressure <= sat20(dp_raw);
                delta_temp     <= sat20(dt_raw);
                if (pend_p_q < min_pressure) min_pressure <= pend_p_q;
                if (pend_p_q > max_pressure) max_pressure <= pend_p_q;
                if ($signed(pend_t_q) < $signed(min_temp)) min_temp <= pend_t_q;
                if ($signed(pend_t_q) > $signed(max_temp)) max_temp <= pend_t_q;
                if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
            end
        end else begin
            sample_valid <= 1'b0;
`ifdef ALT_STATS_CLEAR_EN
            if (stats_clear) begin
                stats_valid    <= 1'b0;
                sample_count   <= '0;
                delta_pressure <= '0;
                delta_temp     <= '0;
                min_pressure   <= '0;
                max_pressure   <= '0;
                min_temp       <= '0;
                max_temp       <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alt_sample_stats.sv
// Scoreboard bench for alt_sample_stats: directed frames push expected samples, a monitor checks them.
module tb_alt_sample_stats;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        frame_start = 1'b0;
    logic        frame_abort = 1'b0;
    logic [19:0] pressure, temp, delta_pressure, delta_temp;
    logic [19:0] min_pressure, max_pressure, min_temp, max_temp;
    logic        sample_valid, stats_valid, frame_drop;
    logic [15:0] sample_count;
`ifdef ALT_STATS_CLEAR_EN
    logic        stats_clear = 1'b0;
`endif

    alt_sample_stats #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .frame_start    (frame_start),
        .frame_abort    (frame_abort),
`ifdef ALT_STATS_CLEAR_EN
        .stats_clear    (stats_clear),
`endif
        .pressure       (pressure),
        .temp           (temp),
        .delta_pressure (delta_pressure),
        .delta_temp     (delta_temp),
        .min_pressure   (min_pressure),
        .max_pressure   (max_pressure),
        .min_temp       (min_temp),
        .max_temp       (max_temp),
        .sample_valid   (sample_valid),
        .stats_valid    (stats_valid),
        .sample_count   (sample_count),
        .frame_drop     (frame_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] p, t, dp, dt, minp, maxp, mint, maxt;
        logic [15:0] cnt;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   drops = 0;
    int   last_edge = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: samples #1 after each edge, pops one expectation per sample_valid pulse.
    always @(posedge clk) begin
        #1;
        if (frame_drop) drops++;
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pressure", 32'(pressure), 32'(mon_e.p));
                chk("temp", 32'(temp), 32'(mon_e.t));
                chk("delta_pressure", 32'(delta_pressure), 32'(mon_e.dp));
                chk("delta_temp", 32'(delta_temp), 32'(mon_e.dt));
                chk("min_pressure", 32'(min_pressure), 32'(mon_e.minp));
                chk("max_pressure", 32'(max_pressure), 32'(mon_e.maxp));
                chk("min_temp", 32'(min_temp), 32'(mon_e.mint));
                chk("max_temp", 32'(max_temp), 32'(mon_e.maxt));
                chk("sample_count", 32'(sample_count), 32'(mon_e.cnt));
                chk("stats_valid", 32'(stats_valid), 32'd1);
                chk("sample_edge", 32'(edge_cnt), 32'(mon_e.edge_n));
            end
        end
    end

    function automatic exp_t mk(input logic [19:0] p, t, dp, dt, minp, maxp, mint, maxt,
                                input logic [15:0] cnt);
        exp_t e;
        e.p = p; e.t = t; e.dp = dp; e.dt = dt;
        e.minp = minp; e.maxp = maxp; e.mint = mint; e.maxt = maxt;
        e.cnt = cnt; e.edge_n = 0;
        return e;
    endfunction

    task automatic put(input logic [7:0] d, input logic st);
        @(negedge clk);
        last_edge   = edge_cnt;
        byte_valid  = 1'b1;
        byte_data   = d;
        frame_start = st;
        frame_abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid  = 1'b0;
            frame_start = 1'b0;
            frame_abort = 1'b0;
        end
    endtask

    // Sample expected one edge after the 5th byte's capture edge.
    task automatic frame(input logic [7:0] b0, b1, b2, b3, b4, input exp_t e);
        exp_t x;
        put(b0, 1'b1);
        put(b1, 1'b0);
        put(b2, 1'b0);
        put(b3, 1'b0);
        put(b4, 1'b0);
        x = e;
        x.edge_n = last_edge + 2;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] acc;
        acc = 32'(pressure | temp | delta_pressure | delta_temp | min_pressure | max_pressure |
                  min_temp | max_temp);
        chk({tag, "_data_outputs"}, acc, 32'd0);
        chk({tag, "_sample_count"}, 32'(sample_count), 32'd0);
        chk({tag, "_flags"}, 32'({sample_valid, stats_valid, frame_drop}), 32'd0);
    endtask

    initial begin
        idle(2);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk_all_zero("post_reset");

        frame(8'h12, 8'h34, 8'h56, 8'h19, 8'h80, mk(20'h12345, 20'h00198, 20'h0, 20'h0,
              20'h12345, 20'h12345, 20'h00198, 20'h00198, 16'd1));
        frame(8'h12, 8'h34, 8'h66, 8'hF6, 8'h00, mk(20'h12346, 20'hFFF60, 20'h00001, 20'hFFDC8,
              20'h12345, 20'h12346, 20'hFFF60, 20'h00198, 16'd2));
        frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, mk(20'h00000, 20'h00000, 20'hEDCBA, 20'h000A0,
              20'h00000, 20'h12346, 20'hFFF60, 20'h00198, 16'd3));
        frame(8'hFF, 8'hFF, 8'hF0, 8'h7F, 8'hF0, mk(20'hFFFFF, 20'h007FF, 20'h7FFFF, 20'h007FF,
              20'h00000, 20'hFFFFF, 20'hFFF60, 20'h007FF, 16'd4));
        frame(8'h00, 8'h00, 8'h00, 8'h80, 8'h00, mk(20'h00000, 20'hFF800, 20'h80000, 20'hFF001,
              20'h00000, 20'hFFFFF, 20'hFF800, 20'h007FF, 16'd5));
        idle(3);
        drain();
        chk("drops_before_faults", 32'(drops), 32'd0);

        // Abort after 3 bytes.
        put(8'h12, 1'b1);
        put(8'h34, 1'b0);
        put(8'h56, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0; frame_start = 1'b0; frame_abort = 1'b1;
        idle(3);
        chk("drops_after_abort", 32'(drops), 32'd1);
        chk("abort_pressure_held", 32'(pressure), 32'h00000);
        chk("abort_temp_held", 32'(temp), 32'hFF800);
        chk("abort_count_held", 32'(sample_count), 32'd5);

        // Abort together with a frame_start byte: byte ignored, following bytes need a new start.
        put(8'h12, 1'b1);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'hAA; frame_start = 1'b1; frame_abort = 1'b1;
        put(8'h34, 1'b0);
        put(8'h56, 1'b0);
        put(8'h78, 1'b0);
        put(8'h9A, 1'b0);
        idle(3);
        chk("drops_after_abort_byte", 32'(drops), 32'd2);

        // Timeout, then a frame with a stall just short of the limit.
        put(8'h01, 1'b1);
        put(8'h02, 1'b0);
        idle(TO + 3);
        chk("drops_after_timeout", 32'(drops), 32'd3);
        put(8'h01, 1'b1);
        put(8'h00, 1'b0);
        idle(TO - 2);
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        put(8'h10, 1'b0);
        exp_q.push_back(mk(20'h01000, 20'h00001, 20'h01000, 20'h00801,
                           20'h00000, 20'hFFFFF, 20'hFF800, 20'h007FF, 16'd6));
        exp_q[exp_q.size() - 1].edge_n = last_edge + 2;
        idle(3);
        drain();
        chk("drops_after_stall_frame", 32'(drops), 32'd3);

        // Resync mid-frame.
        put(8'h12, 1'b1);
        put(8'h34, 1'b0);
        frame(8'h0A, 8'hBC, 8'hDE, 8'h00, 8'h50, mk(20'h0ABCD, 20'h00005, 20'h09BCD, 20'h00004,
              20'h00000, 20'hFFFFF, 20'hFF800, 20'h007FF, 16'd7));
        idle(3);
        drain();
        chk("drops_after_resync", 32'(drops), 32'd4);

        // Reset mid-frame.
        put(8'h12, 1'b1);
        put(8'h34, 1'b0);
        put(8'h56, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0; frame_start = 1'b0; rst_n = 1'b0;
        #1;
        chk_all_zero("mid_frame_reset");
        idle(2);
        rst_n = 1'b1;
        put(8'h78, 1'b0);
        put(8'h9A, 1'b0);
        idle(3);
        chk_all_zero("after_reset_release");
        chk("drops_after_reset", 32'(drops), 32'd4);

        // Back-to-back: second P_MSB lands on the first frame's commit edge.
        frame(8'h00, 8'h00, 8'h10, 8'h00, 8'h20, mk(20'h00001, 20'h00002, 20'h0, 20'h0,
              20'h00001, 20'h00001, 20'h00002, 20'h00002, 16'd1));
        frame(8'h00, 8'h00, 8'h20, 8'h00, 8'h30, mk(20'h00002, 20'h00003, 20'h00001, 20'h00001,
              20'h00001, 20'h00002, 20'h00002, 20'h00003, 16'd2));
        idle(3);
        drain();
        chk("final_sample_count", 32'(sample_count), 32'd2);
        chk("final_drops", 32'(drops), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
